// File: rtl/param_cache.sv
// ============================================================================
//  Module      : param_cache
//  Description : Parametrised write-through, write-allocate cache, one word
//                per line, 1 or 2 ways with per-set LRU, valid/ready request
//                port, held-until-ack backing-memory port, bulk invalidate.
//                Optional hit/miss statistics when PARAM_CACHE_STATS_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_cache #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 2,
    parameter int ASSOC   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_hit,
    input  logic              inv_all,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef PARAM_CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MISS  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state;
    logic [ASSOC-1:0]    valid_q [SETS];
    logic [TAG_W-1:0]    tag_q   [ASSOC][SETS];
    logic [DATA_W-1:0]   data_q  [ASSOC][SETS];
    logic [SETS-1:0]     lru_q;           // per set: the way to evict next
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                lat_hit;
    logic                fill_way;

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag_in;
    logic [INDEX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic [ASSOC-1:0]    hit_vec;
    logic                hit;
    logic                hit_way;
    logic [DATA_W-1:0]   hit_data;
    logic                victim;
    logic                acc_way;
    logic                accept;

    generate
        if (ASSOC != 1 && ASSOC != 2) begin : g_bad_assoc
            $error("param_cache: ASSOC must be 1 or 2");
        end
    endgenerate

    assign idx       = req_addr[INDEX_W-1:0];
    assign tag_in    = req_addr[ADDR_W-1:INDEX_W];
    assign fill_idx  = lat_addr[INDEX_W-1:0];
    assign fill_tag  = lat_addr[ADDR_W-1:INDEX_W];
    assign req_ready = (state == S_IDLE) && !inv_all;
    assign accept    = req_ready && req_valid;
    assign hit       = |hit_vec;
    assign acc_way   = hit ? hit_way : victim;

    // Tag compare across all ways of the addressed set in the acceptance cycle
    always_comb begin
        hit_vec  = '0;
        hit_way  = 1'b0;
        hit_data = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (valid_q[idx][w] && (tag_q[w][idx] == tag_in)) begin
                hit_vec[w] = 1'b1;
                hit_way    = w[0];
                hit_data   = data_q[w][idx];
            end
        end
    end

    // Victim choice: first invalid way, otherwise the LRU way
    generate
        if (ASSOC == 2) begin : g_victim_2way
            assign victim = !valid_q[idx][0] ? 1'b0 :
                            !valid_q[idx][1] ? 1'b1 : lru_q[idx];
        end else begin : g_victim_1way
            assign victim = 1'b0;
        end
    endgenerate

    // Control FSM, valid/LRU state and registered response/memory outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            lru_q     <= '0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_rdata <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_hit   <= 1'b0;
            fill_way  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (inv_all) begin
                        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
                        lru_q <= '0;
                    end else if (req_valid) begin
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_hit   <= hit;
                        fill_way  <= acc_way;
                        if (req_wr) begin
                            // Line is allocated/updated now; memory write follows
                            valid_q[idx][acc_way] <= 1'b1;
                            if (ASSOC == 2) lru_q[idx] <= ~acc_way;
                            mem_req   <= 1'b1;
                            mem_wr    <= 1'b1;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata;
                            state     <= S_WRITE;
                        end else if (hit) begin
                            if (ASSOC == 2) lru_q[idx] <= ~hit_way;
                            rsp_valid <= 1'b1;
                            rsp_hit   <= 1'b1;
                            rsp_rdata <= hit_data;
                            state     <= S_RESP;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_wr   <= 1'b0;
                            mem_addr <= req_addr;
                            state    <= S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    if (mem_ack) begin
                        valid_q[fill_idx][fill_way] <= 1'b1;
                        if (ASSOC == 2) lru_q[fill_idx] <= ~fill_way;
                        mem_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_hit   <= 1'b0;
                        rsp_rdata <= mem_rdata;
                        state     <= S_RESP;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_wr    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_hit   <= lat_hit;
                        rsp_rdata <= lat_wdata;
                        state     <= S_RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    rsp_hit   <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // Tag/data storage: written on write acceptance or on a miss fill
    always_ff @(posedge clk) begin
        if (accept && req_wr) begin
            tag_q[acc_way][idx]  <= tag_in;
            data_q[acc_way][idx] <= req_wdata;
        end else if (state == S_MISS && mem_ack) begin
            tag_q[fill_way][fill_idx]  <= fill_tag;
            data_q[fill_way][fill_idx] <= mem_rdata;
        end
    end

`ifdef PARAM_CACHE_STATS_EN
    // Saturating read hit/miss counters, cleared by an accepted invalidate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == S_IDLE && inv_all) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (accept && !req_wr) begin
            if (hit && hit_cnt != 32'hFFFF_FFFF)    hit_cnt  <= hit_cnt + 32'd1;
            if (!hit && miss_cnt != 32'hFFFF_FFFF)  miss_cnt <= miss_cnt + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration
`endif

endmodule

`default_nettype wire

// File: tb/tb_param_cache.sv
// ============================================================================
//  Module      : tb_param_cache
//  Description : Scoreboard bench for param_cache (default parameters).
//                Expected responses are queued at issue; a negedge monitor
//                pops and compares every rsp_valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_cache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_hit;
    logic        inv_all = 1'b0;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef PARAM_CACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [32:0] sb_q [$];   // {rdata, hit}

    always #5 clk = ~clk;

    param_cache dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_hit   (rsp_hit),
        .inv_all   (inv_all),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef PARAM_CACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", {31'd0, rsp_hit, rsp_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e[31:0]});
                chk("rsp_hit", {63'd0, rsp_hit}, {63'd0, e[32]});
            end
        end
    end

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin @(negedge clk); #1; n++; end
        if (sb_q.size() != 0) begin
            chk("rsp_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        @(negedge clk);
        chk("rsp_single_pulse", {63'd0, rsp_valid}, 0);
    endtask

    task automatic mem_svc(input logic exp_wr, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, input int hold,
                           input logic [31:0] rdata, input bit pulse_inv);
        int n = 0;
        @(negedge clk);
        while (!mem_req && n < 20) begin @(negedge clk); n++; end
        if (!mem_req) begin chk("mem_req_timeout", 0, 1); return; end
        chk("mem_wr", {63'd0, mem_wr}, {63'd0, exp_wr});
        chk("mem_addr", {32'd0, mem_addr}, {32'd0, exp_addr});
        if (exp_wr) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, exp_wdata});
        for (int i = 1; i < hold; i++) begin
            if (pulse_inv && i == 1) inv_all = 1'b1;
            @(posedge clk); #1;
            inv_all = 1'b0;
            @(negedge clk);
            chk("mem_req_held", {63'd0, mem_req}, 1);
            chk("mem_addr_held", {32'd0, mem_addr}, {32'd0, exp_addr});
        end
        mem_ack = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("mem_req_drop", {63'd0, mem_req}, 0);
        chk("rsp_after_ack", {63'd0, rsp_valid}, 1);
    endtask

    task automatic read_miss(input logic [31:0] addr, input logic [31:0] rdata,
                             input int hold, input bit pulse_inv);
        sb_q.push_back({1'b0, rdata});
        do_req(1'b0, addr, '0);
        mem_svc(1'b0, addr, '0, hold, rdata, pulse_inv);
        drain();
    endtask

    task automatic read_hit(input logic [31:0] addr, input logic [31:0] exp);
        sb_q.push_back({1'b1, exp});
        do_req(1'b0, addr, '0);
        @(negedge clk);
        chk("hit_latency", {63'd0, rsp_valid}, 1);
        chk("hit_no_mem_req", {63'd0, mem_req}, 0);
        drain();
    endtask

    task automatic write_req(input logic [31:0] addr, input logic [31:0] data,
                             input logic exp_hit, input int hold);
        sb_q.push_back({exp_hit, data});
        do_req(1'b1, addr, data);
        mem_svc(1'b1, addr, data, hold, 32'h0, 1'b0);
        drain();
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_mem_req", {63'd0, mem_req}, 0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 1);

        // Cold miss then hit
        read_miss(32'h10, 32'hDEAD_BEEF, 3, 1'b0);
        read_hit(32'h10, 32'hDEAD_BEEF);
`ifdef PARAM_CACHE_STATS_EN
        chk("stats_hit", {32'd0, hit_cnt}, 1);
        chk("stats_miss", {32'd0, miss_cnt}, 1);
`endif

        // Stray ack with no outstanding request produces nothing
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_rsp", {63'd0, rsp_valid}, 0);
        chk("stray_ack_req", {63'd0, mem_req}, 0);

        // LRU eviction in set 0 (0x10 already occupies way 0)
        read_miss(32'h4, 32'hA, 1, 1'b0);
        read_miss(32'h8, 32'hB, 1, 1'b0);
        read_hit(32'h4, 32'hA);
        read_miss(32'hC, 32'hC0, 1, 1'b0);
        read_hit(32'h4, 32'hA);
        read_miss(32'h8, 32'hB, 1, 1'b0);

        // Write-through: allocate on miss, then hit, then overwrite on hit
        write_req(32'h5, 32'h1234, 1'b0, 2);
        read_hit(32'h5, 32'h1234);
        write_req(32'h5, 32'h5678, 1'b1, 1);
        read_hit(32'h5, 32'h5678);

        // Bulk invalidate has priority over a pending request
        @(negedge clk);
        inv_all = 1'b1; req_valid = 1'b1; req_addr = 32'h5; req_wr = 1'b0;
        #1 chk("inv_req_ready", {63'd0, req_ready}, 0);
        @(posedge clk); #1;
        inv_all = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("inv_no_mem_req", {63'd0, mem_req}, 0);
`ifdef PARAM_CACHE_STATS_EN
        chk("inv_stats_hit", {32'd0, hit_cnt}, 0);
        chk("inv_stats_miss", {32'd0, miss_cnt}, 0);
`endif
        read_miss(32'h5, 32'h9999, 1, 1'b0);
        // Invalidate pulsed during MISS is ignored
        read_miss(32'h10, 32'hDEAD_BEEF, 3, 1'b1);
        read_hit(32'h10, 32'hDEAD_BEEF);

        // Asynchronous reset in the middle of a miss
        do_req(1'b0, 32'h20, '0);
        @(negedge clk);
        chk("pre_rst_mem_req", {63'd0, mem_req}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", {63'd0, mem_req}, 0);
        chk("async_rst_rsp_valid", {63'd0, rsp_valid}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        read_miss(32'h10, 32'h77, 1, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
